// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: fetch FSM states,
// the NOP returned on faults and the address fault check.
package riscv_defs;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          IMEM_MAX_WAIT = 7;

  typedef enum logic [1:0] {
    IMEM_IDLE,
    IMEM_WAIT,
    IMEM_RESP
  } imem_state_t;

  // Full 30-bit word-index compare so high addresses never alias into the array.
  function automatic logic imem_fault(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels plus the program-load write port.
// master = PC unit / loader side, slave = memory responder side.
interface imem_responder_if #(
  parameter int DEPTH_WORDS = 1024
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic          rsp_err;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_wdata;

  modport master (
    output req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_wdata,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, prog_we, prog_addr, prog_wdata,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );

endinterface

// File: rtl/imem_responder_array.sv
// Instruction storage: DEPTH_WORDS x 32, one sync write port, one sync read port.
// Read data appears one edge after re; no backpressure, contents not reset.
// A read and write to the same word on one edge returns the old word.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one 32-bit word per word-aligned fetch.
// Latency 1+WAIT_CYCLES from accept to rsp_valid; one request outstanding.
// Response held until rsp_ready; a new request is taken on the same handshake.
module imem_responder
  import riscv_defs::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_responder_if.slave   bus
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  imem_state_t state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        err_q;
  logic        data_ok_q;
  logic        accept;
  logic        capture;
  logic [31:0] cap_addr;
  logic        cap_fault;
  logic [31:0] rd_data;

  assign bus.req_ready = rst_n && ((state_q == IMEM_IDLE) ||
                                   ((state_q == IMEM_RESP) && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;

  // Without wait states the array is read on the accept edge itself.
  assign cap_addr  = (WAIT_CYCLES == 0) ? bus.req_addr : addr_q;
  assign cap_fault = imem_fault(cap_addr, DEPTH_WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IMEM_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = IMEM_RESP;
            capture = 1'b1;
          end else begin
            state_d = IMEM_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      IMEM_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = IMEM_RESP;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      IMEM_RESP: begin
        if (bus.rsp_ready) begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              state_d = IMEM_RESP;
              capture = 1'b1;
            end else begin
              state_d = IMEM_WAIT;
              cnt_d   = WAIT_LD;
            end
          end else begin
            state_d = IMEM_IDLE;
          end
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IMEM_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 32'd0;
      err_q     <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= bus.req_addr;
      end
      if (capture) begin
        err_q     <= cap_fault;
        data_ok_q <= !cap_fault;
      end
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (bus.prog_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_wdata),
    .re    (capture),
    .raddr (cap_addr[AW+1:2]),
    .rdata (rd_data)
  );

  // rd_data only updates on capture, so a held response survives later loads.
  assign bus.rsp_valid = (state_q == IMEM_RESP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_instr = data_ok_q ? rd_data : NOP_INSTR;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: one responder with no wait states, one with three.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_responder_if #(.DEPTH_WORDS(1024)) i0 ();
  imem_responder_if #(.DEPTH_WORDS(1024)) i3 ();

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i0)
  );

  imem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    i0.prog_we = 1'b1; i0.prog_addr = a; i0.prog_wdata = d;
    i3.prog_we = 1'b1; i3.prog_addr = a; i3.prog_wdata = d;
    @(negedge clk);
    i0.prog_we = 1'b0;
    i3.prog_we = 1'b0;
  endtask

  // Single fetch on the zero-wait responder with rsp_ready held high.
  task automatic fetch0(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_instr, input logic exp_err);
    i0.req_valid = 1'b1;
    i0.req_addr  = a;
    @(negedge clk);
    i0.req_valid = 1'b0;
    check({tag, "_vld"},   i0.rsp_valid, 1);
    check({tag, "_instr"}, i0.rsp_instr, exp_instr);
    check({tag, "_err"},   i0.rsp_err,   exp_err);
    @(negedge clk);
    check({tag, "_idle"},  i0.rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int extra;
    logic [31:0] held;

    rst_n = 1'b0;
    i0.req_valid = 1'b0; i0.req_addr = '0; i0.rsp_ready = 1'b0;
    i0.prog_we = 1'b0; i0.prog_addr = '0; i0.prog_wdata = '0;
    i3.req_valid = 1'b0; i3.req_addr = '0; i3.rsp_ready = 1'b0;
    i3.prog_we = 1'b0; i3.prog_addr = '0; i3.prog_wdata = '0;
    repeat (2) @(negedge clk);

    check("rst_vld0",   i0.rsp_valid, 0);
    check("rst_rdy0",   i0.req_ready, 0);
    check("rst_instr0", i0.rsp_instr, 32'h0000_0013);
    check("rst_err0",   i0.rsp_err,   0);
    check("rst_vld3",   i3.rsp_valid, 0);
    check("rst_rdy3",   i3.req_ready, 0);
    rst_n = 1'b1;

    load(10'd0,    32'h0010_0093);
    load(10'd1,    32'h0020_0113);
    load(10'd1023, 32'hDEAD_BEEF);

    // Back-to-back fetches at full throughput.
    i0.rsp_ready = 1'b1;
    i0.req_valid = 1'b1;
    i0.req_addr  = 32'h0;
    #1 check("b2b_rdy_a", i0.req_ready, 1);
    @(negedge clk);
    check("b2b_vld_a",   i0.rsp_valid, 1);
    check("b2b_instr_a", i0.rsp_instr, 32'h0010_0093);
    check("b2b_err_a",   i0.rsp_err,   0);
    i0.req_addr = 32'h4;
    #1 check("b2b_rdy_b", i0.req_ready, 1);
    @(negedge clk);
    check("b2b_vld_b",   i0.rsp_valid, 1);
    check("b2b_instr_b", i0.rsp_instr, 32'h0020_0113);
    i0.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_idle",    i0.rsp_valid, 0);
    check("b2b_keep",    i0.rsp_instr, 32'h0020_0113);

    // Faults and the last in-range word.
    fetch0("misalign", 32'h0000_0002, 32'h0000_0013, 1'b1);
    fetch0("range",    32'h0000_1000, 32'h0000_0013, 1'b1);
    fetch0("top",      32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0);

    // Load on the capture edge returns the old word.
    i0.req_valid  = 1'b1;
    i0.req_addr   = 32'h0;
    i0.prog_we    = 1'b1;
    i0.prog_addr  = 10'd0;
    i0.prog_wdata = 32'h1111_1111;
    @(negedge clk);
    i0.req_valid = 1'b0;
    i0.prog_we   = 1'b0;
    check("rbw_old", i0.rsp_instr, 32'h0010_0093);
    @(negedge clk);
    fetch0("rbw_new", 32'h0, 32'h1111_1111, 1'b0);

    // Three wait states: rsp_valid exactly four cycles after accept.
    i3.rsp_ready = 1'b0;
    i3.req_valid = 1'b1;
    i3.req_addr  = 32'h4;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        check("wait_vld", i3.rsp_valid, 0);
        check("wait_rdy", i3.req_ready, 0);
        i3.req_valid = c[0];
        i3.req_addr  = 32'h0;
      end else begin
        check("wait_done_vld", i3.rsp_valid, 1);
        check("wait_instr",    i3.rsp_instr, 32'h0020_0113);
        check("wait_err",      i3.rsp_err,   0);
      end
    end

    // Stall: response held, requests ignored, loads do not disturb it.
    held = 32'h0020_0113;
    for (int h = 0; h < 5; h++) begin
      if (h > 0) @(negedge clk);
      i3.prog_we = 1'b0;
      check("hold_vld",   i3.rsp_valid, 1);
      check("hold_instr", i3.rsp_instr, held);
      i3.req_valid = h[0];
      i3.req_addr  = 32'(h * 4);
      if (h == 2) begin
        i3.prog_we    = 1'b1;
        i3.prog_addr  = 10'd1;
        i3.prog_wdata = 32'hCAFE_F00D;
      end
      #1 check("hold_rdy", i3.req_ready, 0);
    end
    @(negedge clk);
    i3.prog_we   = 1'b0;
    i3.req_valid = 1'b0;
    i3.rsp_ready = 1'b1;
    #1 check("rel_rdy", i3.req_ready, 1);
    @(negedge clk);
    check("rel_vld", i3.rsp_valid, 0);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (i3.rsp_valid) extra++;
    end
    check("rel_no_extra", extra, 0);

    // Reset while waiting drops the request; the array survives.
    i3.req_valid = 1'b1;
    i3.req_addr  = 32'h0;
    @(negedge clk);
    i3.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", i3.rsp_valid, 0);
    check("mid_rst_rdy", i3.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i3.rsp_valid) extra++;
    end
    check("post_rst_stale", extra, 0);

    i3.req_valid = 1'b1;
    i3.req_addr  = 32'h0;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i3.req_valid = 1'b0;
      if (i3.rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("post_rst_lat",   lat,          4);
    check("post_rst_instr", i3.rsp_instr, 32'h0010_0093);
    check("post_rst_err",   i3.rsp_err,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface that the PC unit drives.
- Accepts word-aligned fetch addresses over a valid/ready request channel and returns one 32-bit instruction per request over a valid/ready response channel.
- Supports configurable wait states.
- Provides a word-indexed program-load write port for bench/boot loading.
- Flags misaligned and out-of-range fetches.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two, at least 4.
- WAIT_CYCLES, 0: extra cycles between request acceptance and response valid; range 0..7.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  responder can accept a request this cycle
- req_addr  in  32  byte address of the instruction (PC)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_instr  out  32  fetched instruction
- rsp_err  out  1  fetch fault: misaligned or out of range
- prog_we  in  1  program-load write enable
- prog_addr  in  $clog2(DEPTH_WORDS)  word index for the load write
- prog_wdata  in  32  load data

Behaviour:
- States (riscv_defs::imem_state_t): IMEM_IDLE, IMEM_WAIT, IMEM_RESP.
- Reset (async, rst_n low): state IMEM_IDLE, rsp_valid=0, rsp_err=0, rsp_instr=NOP_INSTR (32'h0000_0013), wait counter=0.
- During reset: req_ready=0. Array contents are not reset.
- req_ready is combinational: 1 when (state==IMEM_IDLE) or (state==IMEM_RESP and rsp_ready); otherwise 0.
- Accept when req_valid && req_ready; req_addr is latched on that edge.
- Fault check on the latched address:
  - misaligned = addr[1:0] != 0
  - out of range = addr[31:2] >= DEPTH_WORDS (compare full 30 bits; no wrap-around or aliasing)
- On accept with WAIT_CYCLES==0: next state IMEM_RESP; rsp_valid=1 on the cycle after acceptance.
- On accept with WAIT_CYCLES>0: next state IMEM_WAIT; counter loaded with WAIT_CYCLES-1, decremented each cycle.
- IMEM_WAIT exits to IMEM_RESP on the edge when the counter reaches 0. rsp_valid rises exactly 1+WAIT_CYCLES cycles after acceptance.
- On entering IMEM_RESP, the outputs are registered from the array read:
  - fault: rsp_instr=NOP_INSTR, rsp_err=1
  - otherwise: rsp_instr=mem[addr[IDX+1:2]], rsp_err=0
- In IMEM_RESP, rsp_valid, rsp_instr and rsp_err are held stable until rsp_valid && rsp_ready.
- On response handshake:
  - with a simultaneous request accept: behave as acceptance from IDLE (back-to-back; throughput of 1 per cycle when WAIT_CYCLES==0).
  - with no new request: go to IMEM_IDLE, rsp_valid=0, rsp_instr/rsp_err keep their last values.
- At most one outstanding request. req_valid is ignored in IMEM_WAIT and in IMEM_RESP without rsp_ready.
- Program-load writes:
  - prog_we writes mem[prog_addr] on the clock edge, in any state.
  - Read-before-write: a write on the same edge as the response capture returns the old word.
  - Writes after capture do not alter a held response.
- Reset mid-operation: the pending request is dropped and no response is produced. After reset release, the first accept is serviced normally.

Decomposition:
- riscv_defs package:
  - NOP_INSTR constant
  - imem_state_t enum
  - IMEM_MAX_WAIT=7 constant
- One sub-module, imem_array:
  - DEPTH_WORDS x 32 storage, no reset
  - one synchronous write port, one synchronous read port, read-before-write
- imem_responder contains the FSM, wait counter, fault check and handshake.

Test Plan:
- Load: mem[0]=32'h0010_0093, mem[1]=32'h0020_0113. WAIT_CYCLES=0, rsp_ready held 1, requests 0x0 then 0x4 back-to-back -> rsp_valid on cycles 1 and 2 with 32'h0010_0093, then 32'h0020_0113; rsp_err=0; req_ready stays 1.
- WAIT_CYCLES=3, request 0x4 -> rsp_valid rises exactly 4 cycles after acceptance; req_ready=0 during the wait; data 32'h0020_0113.
- rsp_ready held 0 for 5 cycles after rsp_valid; toggle req_valid/req_addr meanwhile -> rsp_instr stable, req_ready=0, no new acceptance; release -> single handshake, then return to IDLE.
- Request 0x2 -> rsp_err=1, rsp_instr=32'h0000_0013.
- DEPTH_WORDS=1024, request 0x1000 -> rsp_err=1, rsp_instr=32'h0000_0013; no alias to mem[0].
- Assert rst_n low while in IMEM_WAIT -> rsp_valid=0, req_ready=0 immediately. After release, request 0x0 returns 32'h0010_0093 (array retained); no stale response is produced.
